// File: rtl/mux8_rr_arbiter_if.sv
// Handshake bundle between the 8 requesting sources / downstream sink and the
// round-robin arbiter that steers the shared 8:1 32-bit selector.
interface mux8_rr_arbiter_if;
    logic [7:0]  req;
    logic [2:0]  sel;
    logic [31:0] mux_o;
    logic [7:0]  gnt;
    logic [7:0]  ack;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    // slave: the arbiter itself; master: sources, selector and downstream sink
    modport slave (
        input  req, mux_o, dout_ready,
        output sel, gnt, ack, dout, dout_valid
    );
    modport master (
        output req, mux_o, dout_ready,
        input  sel, gnt, ack, dout, dout_valid
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for an 8:1 32-bit selector: grants bursts of up to BURST
// beats, captures the selected word into a valid/ready output register.
module mux8_rr_arbiter #(
    parameter int unsigned BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mux8_rr_arbiter_if.slave   bus
);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e      state_q;
    logic [2:0]  ptr_q;
    logic [3:0]  cnt_q;
    logic [2:0]  win;
    logic        cap_ok;
    logic        cap;
    logic        last_beat;

    // Scan downward so the lowest offset from ptr_q is the final assignment.
    always_comb begin
        win = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            if (bus.req[ptr_q + 3'(k)]) begin
                win = ptr_q + 3'(k);
            end
        end
    end

    assign cap_ok    = !bus.dout_valid || bus.dout_ready;
    assign cap       = (state_q == StXfer) && bus.req[bus.sel] && cap_ok;
    assign last_beat = (cnt_q + 4'd1) == 4'(BURST);
    assign bus.ack   = cap ? (8'b0000_0001 << bus.sel) : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            ptr_q          <= 3'd0;
            cnt_q          <= 4'd0;
            bus.sel        <= 3'd0;
            bus.gnt        <= 8'h00;
            bus.dout       <= 32'h0;
            bus.dout_valid <= 1'b0;
        end else begin
            if (cap) begin
                bus.dout       <= bus.mux_o;
                bus.dout_valid <= 1'b1;
            end else if (bus.dout_ready) begin
                bus.dout_valid <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (|bus.req) begin
                        bus.sel <= win;
                        bus.gnt <= 8'b0000_0001 << win;
                        cnt_q   <= 4'd0;
                        state_q <= StXfer;
                    end
                end
                StXfer: begin
                    // sel is left untouched on release; only the pointer moves on.
                    if (!bus.req[bus.sel] || (cap_ok && last_beat)) begin
                        bus.gnt <= 8'h00;
                        ptr_q   <= bus.sel + 3'd1;
                        state_q <= StIdle;
                    end else if (cap_ok) begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomised bench for mux8_rr_arbiter: a transaction-level arbitration model
// predicts acks and captured words; a separate monitor scores consumed beats.
module tb_mux8_rr_arbiter;

    localparam int unsigned BURST = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux8_rr_arbiter_if bus ();

    // The external 8:1 selector: each source's current word, steered by sel.
    logic [31:0] words [8];
    assign bus.mux_o = words[bus.sel];

    mux8_rr_arbiter #(.BURST(BURST)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];
    int          budget [8];
    logic [7:0]  ack_prev;
    bit          rand_mode;

    // Reference model state
    bit          m_busy;
    int          m_owner;
    int          m_beats;
    int          m_ptr;
    logic [2:0]  m_sel;
    logic        m_dv;
    logic [31:0] m_dout;
    logic [7:0]  e_ack;
    logic [7:0]  e_gnt;
    bit          e_cap;
    bit          e_rel;
    bit          found;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: evaluated once per cycle with inputs and registered outputs stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_ptr    = 0;
            m_sel    = 3'd0;
            m_dv     = 1'b0;
            m_dout   = 32'h0;
            ack_prev = 8'h00;
            exp_q.delete();
            check("rst_sel", 32'(bus.sel), 32'h0);
            check("rst_gnt", 32'(bus.gnt), 32'h0);
            check("rst_ack", 32'(bus.ack), 32'h0);
            check("rst_dout_valid", 32'(bus.dout_valid), 32'h0);
            check("rst_dout", bus.dout, 32'h0);
        end else begin
            e_ack = 8'h00;
            e_cap = 1'b0;
            e_rel = 1'b0;
            check("sel", 32'(bus.sel), 32'(m_sel));
            check("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
            check("dout", bus.dout, m_dout);
            if (!m_busy) begin
                check("gnt_idle", 32'(bus.gnt), 32'h0);
                if (bus.req != 8'h00) begin
                    found = 1'b0;
                    for (int k = 0; k < 8; k++) begin
                        if (!found && bus.req[(m_ptr + k) % 8]) begin
                            found   = 1'b1;
                            m_owner = (m_ptr + k) % 8;
                        end
                    end
                    m_busy  = 1'b1;
                    m_sel   = 3'(m_owner);
                    m_beats = 0;
                end
            end else begin
                e_gnt = 8'h01 << m_owner;
                check("gnt_xfer", 32'(bus.gnt), 32'(e_gnt));
                if (!bus.req[m_owner]) begin
                    e_rel = 1'b1;
                end else if (!m_dv || bus.dout_ready) begin
                    e_cap = 1'b1;
                    e_ack[m_owner] = 1'b1;
                    exp_q.push_back(words[m_owner]);
                    m_beats++;
                    if (m_beats == int'(BURST)) e_rel = 1'b1;
                end
            end
            check("ack", 32'(bus.ack), 32'(e_ack));
            if (e_cap) begin
                m_dv   = 1'b1;
                m_dout = words[m_owner];
            end else if (bus.dout_ready) begin
                m_dv = 1'b0;
            end
            if (e_rel) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % 8;
            end
            ack_prev = bus.ack;
        end
    end

    // Monitor: scores every beat the downstream sink consumes.
    always @(negedge clk) begin
        if (rst_n && bus.dout_valid && bus.dout_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL beat_unexpected: got %h expected none at %0t", bus.dout, $time);
            end else begin
                check("beat_word", bus.dout, exp_q.pop_front());
            end
        end
    end

    // Sources advance on the edge that ends their ack cycle; req follows budget.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (ack_prev[i]) begin
                budget[i]--;
                words[i] = $urandom;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 39) == 0) budget[i] += int'($urandom_range(1, 6));
            end
            if ($urandom_range(0, 49) == 0) budget[$urandom_range(0, 7)] = 0;
            bus.dout_ready = ($urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 8; i++) bus.req[i] = (budget[i] > 0);
    endtask

    bit seen;

    initial begin
        for (int i = 0; i < 8; i++) begin
            words[i]  = $urandom;
            budget[i] = 0;
        end
        words[3]       = 32'hDEAD_BEEF;
        bus.req        = 8'h00;
        bus.dout_ready = 1'b1;
        rand_mode      = 1'b0;
        ack_prev       = 8'h00;
        repeat (2) step();
        rst_n = 1'b1;

        // Single request from source 3
        budget[3] = 1;
        repeat (6) step();

        // Every source requesting: one and two beats per grant
        for (int i = 0; i < 8; i++) budget[i] = 1;
        repeat (30) step();
        for (int i = 0; i < 8; i++) budget[i] = 2;
        repeat (40) step();

        // Burst limit on a continuously requesting source, then early drop
        budget[0] = 10;
        repeat (20) step();
        budget[0] = 2;
        repeat (8) step();

        // Backpressure: stall with a held word, then release
        bus.dout_ready = 1'b0;
        budget[2] = 3;
        repeat (8) step();
        bus.dout_ready = 1'b1;
        repeat (10) step();

        // Asynchronous reset between edges during beat 2
        budget[5] = 4;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            @(negedge clk);
            #1;
            if (ack_prev[5]) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL burst_start_timeout: got no ack expected ack[5] within 20 cycles");
        end
        step();
        #2;
        check("beat2_ack", 32'(bus.ack), 32'h20);
        rst_n = 1'b0;
        #1;
        check("async_ack", 32'(bus.ack), 32'h0);
        check("async_gnt", 32'(bus.gnt), 32'h0);
        check("async_dout_valid", 32'(bus.dout_valid), 32'h0);
        for (int i = 0; i < 8; i++) budget[i] = 0;
        step();
        rst_n = 1'b1;
        budget[6] = 1;
        repeat (6) step();

        // Randomised traffic with random backpressure
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        for (int i = 0; i < 8; i++) budget[i] = 0;
        bus.dout_ready = 1'b1;
        repeat (20) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
